// File: rtl/fuzz_sig_pkg.sv
// fuzz_sig_pkg: shared types and constants for the fuzz signature MISR.
//  - state_t        : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//  - CRC32_POLY     : default CRC-32 feedback polynomial (x^32 term implicit)
//  - chunk_count()  : number of SIG_W-bit chunks needed to cover DATA_W bits
package fuzz_sig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

  // ceil(data_w / sig_w)
  function automatic int chunk_count(input int data_w, input int sig_w);
    return (data_w + sig_w - 1) / sig_w;
  endfunction

endpackage

// File: rtl/fuzz_sig_misr_if.sv
// fuzz_sig_misr_if: control/data bundle between a fuzz harness (master) and
// the signature register (slave).
//  master drives : start, din, din_valid (+ exp_sig with FUZZ_SIG_CMP_EN)
//  slave drives  : busy, done, signature, sample_cnt, state (+ match with FUZZ_SIG_CMP_EN)
// Handshake: start is a single-cycle request honoured only when the slave is
// IDLE or DONE (busy=0); din is consumed on every cycle where din_valid=1 and
// busy=1, with no back-pressure; done is a level held until the next start.
// state is a debug view of the FSM.
// Optional feature macro: FUZZ_SIG_CMP_EN (adds exp_sig / match).
interface fuzz_sig_misr_if
  import fuzz_sig_pkg::*;
#(
  parameter int DATA_W = 284,
  parameter int SIG_W  = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              busy;
  logic              done;
  logic [SIG_W-1:0]  signature;
  logic [CNT_W-1:0]  sample_cnt;
  state_t            state;
`ifdef FUZZ_SIG_CMP_EN
  logic [SIG_W-1:0]  exp_sig;
  logic              match;

  modport master (output start, din, din_valid, exp_sig,
                  input  busy, done, signature, sample_cnt, state, match);
  modport slave  (input  start, din, din_valid, exp_sig,
                  output busy, done, signature, sample_cnt, state, match);
`else
  modport master (output start, din, din_valid,
                  input  busy, done, signature, sample_cnt, state);
  modport slave  (input  start, din, din_valid,
                  output busy, done, signature, sample_cnt, state);
`endif
endinterface

// File: rtl/fuzz_sig_fold.sv
// fuzz_sig_fold: purely combinational XOR fold of a DATA_W vector into SIG_W
// bits. The input is split into ceil(DATA_W/SIG_W) chunks from the LSB up;
// the top chunk is zero-padded in its MSBs.
//  i_din  [DATA_W-1:0] vector to fold
//  o_fold [SIG_W-1:0]  XOR of all chunks
module fuzz_sig_fold
  import fuzz_sig_pkg::*;
#(
  parameter int DATA_W = 284,
  parameter int SIG_W  = 32
) (
  input  logic [DATA_W-1:0] i_din,
  output logic [SIG_W-1:0]  o_fold
);

  localparam int N_CHUNK = chunk_count(DATA_W, SIG_W);
  localparam int PAD_W   = N_CHUNK * SIG_W;

  logic [PAD_W-1:0] w_pad;

  // Zero-extension supplies the MSB padding of the top chunk.
  assign w_pad = PAD_W'(i_din);

  always_comb begin
    o_fold = '0;
    for (int c = 0; c < N_CHUNK; c++) begin
      o_fold = o_fold ^ w_pad[c*SIG_W +: SIG_W];
    end
  end

endmodule

// File: rtl/fuzz_sig_misr.sv
// fuzz_sig_misr: multiple-input signature register for equivalence fuzzing.
// Compacts NUM_SAMPLES valid din vectors into a SIG_W-bit signature.
//  clk  : clock, all state on posedge
//  rst  : synchronous active-high reset
//  bus  : fuzz_sig_misr_if.slave (start/din/din_valid in; busy/done/
//         signature/sample_cnt/state out; exp_sig/match with FUZZ_SIG_CMP_EN)
// Optional feature macro: FUZZ_SIG_CMP_EN registers a signature==exp_sig
// result on the RUN->DONE transition.
module fuzz_sig_misr
  import fuzz_sig_pkg::*;
#(
  parameter int               DATA_W      = 284,
  parameter int               SIG_W       = 32,
  parameter logic [SIG_W-1:0] POLY        = SIG_W'(CRC32_POLY),
  parameter logic [SIG_W-1:0] SEED        = {SIG_W{1'b1}},
  parameter int               NUM_SAMPLES = 64,
  parameter int               CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  fuzz_sig_misr_if.slave  bus
);

  generate
    if (SIG_W < 2) begin : g_bad_sig_w
      $error("fuzz_sig_misr: SIG_W must be >= 2");
    end
    if (NUM_SAMPLES < 1 || NUM_SAMPLES > (2**CNT_W) - 1) begin : g_bad_num
      $error("fuzz_sig_misr: NUM_SAMPLES out of range for CNT_W");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SIG_W-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [SIG_W-1:0] w_fold;
  logic [SIG_W-1:0] w_sig_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_last;

  fuzz_sig_fold #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W)
  ) u_fold (
    .i_din  (bus.din),
    .o_fold (w_fold)
  );

  assign w_start_ok = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_accept   = bus.din_valid && (r_state == RUN);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  // Final sample: the count it produces equals NUM_SAMPLES, so the counter
  // never reaches a value that could wrap.
  assign w_last     = w_accept && (w_cnt_inc == CNT_W'(NUM_SAMPLES));

  // Galois-style shift with feedback, then inject the folded input.
  assign w_sig_nxt  = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? POLY : '0)
                    ^ w_fold;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (bus.start) w_state_nxt = RUN;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= SEED;
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_sig <= SEED;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sig <= w_sig_nxt;
      r_cnt <= w_cnt_inc;
    end
  end

`ifdef FUZZ_SIG_CMP_EN
  logic r_match;

  // Compare against the signature being written on the final edge so match
  // is valid in the very first DONE cycle.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) r_match <= 1'b0;
    else if (w_last)       r_match <= (w_sig_nxt == bus.exp_sig);
  end

  assign bus.match = r_match;
`endif

  assign bus.busy       = (r_state == RUN);
  assign bus.done       = (r_state == DONE);
  assign bus.signature  = r_sig;
  assign bus.sample_cnt = r_cnt;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_fuzz_sig_misr.sv
// tb_fuzz_sig_misr: directed + randomized bench for fuzz_sig_misr.
//  u_a : DATA_W=16, SIG_W=8, POLY=8'h1D, SEED=8'h00, NUM_SAMPLES=4
//  u_b : same but SEED=8'hFF
//  u_c : default 284-bit / 32-bit CRC-32 configuration, 64 samples
// The reference model treats the signature as a polynomial: multiply by x
// modulo POLY using plain integer arithmetic, then add the XOR-folded input.
module tb_fuzz_sig_misr;
  import fuzz_sig_pkg::*;

  localparam int CW = 284;
  localparam int CN = 64;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  fuzz_sig_misr_if #(.DATA_W(16), .SIG_W(8),  .CNT_W(16)) ifa ();
  fuzz_sig_misr_if #(.DATA_W(16), .SIG_W(8),  .CNT_W(16)) ifb ();
  fuzz_sig_misr_if #(.DATA_W(CW), .SIG_W(32), .CNT_W(16)) ifc ();

  fuzz_sig_misr #(.DATA_W(16), .SIG_W(8), .POLY(8'h1D), .SEED(8'h00),
                  .NUM_SAMPLES(4), .CNT_W(16))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  fuzz_sig_misr #(.DATA_W(16), .SIG_W(8), .POLY(8'h1D), .SEED(8'hFF),
                  .NUM_SAMPLES(4), .CNT_W(16))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  fuzz_sig_misr #(.NUM_SAMPLES(CN))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_step(input logic [63:0] sig, input logic [287:0] din,
                                             input int data_w, input int sig_w,
                                             input logic [63:0] poly);
    logic [63:0]  top;
    logic [63:0]  mask;
    logic [63:0]  f;
    logic [63:0]  s;
    logic [287:0] d;
    top  = 64'd1 << sig_w;
    mask = top - 64'd1;
    f    = '0;
    d    = din;
    for (int c = 0; c < (data_w + sig_w - 1) / sig_w; c++) begin
      f = f ^ (d[63:0] & mask);
      d = d >> sig_w;
    end
    s = sig * 64'd2;
    if (s >= top) s = (s - top) ^ poly;
    return (s ^ f) & mask;
  endfunction

  function automatic logic [CW-1:0] rand_wide();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[CW-1:0];
  endfunction

  // ---------------- u_c data and driver ----------------
  logic [CW-1:0] din_c [CN];
  logic [63:0]   clean_c;

  task automatic run_c(input int flip_idx, input int flip_bit);
    logic [63:0]   m;
    logic [CW-1:0] v;
    m = 64'hFFFF_FFFF;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("c_start_busy", ifc.busy, 1'b1);
    chk("c_start_sig", ifc.signature, m);
    for (int i = 0; i < CN; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ifc.din_valid = 1'b0;
        ifc.din       = rand_wide();
        tick();
        chk("c_stall_cnt", ifc.sample_cnt, i);
      end
      v = din_c[i];
      if (i == flip_idx) v[flip_bit] = ~v[flip_bit];
      ifc.din_valid = 1'b1;
      ifc.din       = v;
      tick();
      m = model_step(m, {4'b0, v}, CW, 32, 64'h04C1_1DB7);
      chk("c_sig", ifc.signature, m);
      chk("c_cnt", ifc.sample_cnt, i + 1);
    end
    ifc.din_valid = 1'b0;
    chk("c_done", ifc.done, 1'b1);
    chk("c_busy_end", ifc.busy, 1'b0);
`ifdef FUZZ_SIG_CMP_EN
    chk("c_match", ifc.match, (m == clean_c));
    tick();
    chk("c_match_hold", ifc.match, (m == clean_c));
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("c_match_clr", ifc.match, 1'b0);
    chk("c_restart_cnt", ifc.sample_cnt, 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] m_a;
  int          cnt_a;
  int          pat [5];
  logic [15:0] d4 [4];

  initial begin
    rst = 1'b1;
    ifa.start = 0; ifa.din = '0; ifa.din_valid = 0;
    ifb.start = 0; ifb.din = '0; ifb.din_valid = 0;
    ifc.start = 0; ifc.din = '0; ifc.din_valid = 0;
`ifdef FUZZ_SIG_CMP_EN
    ifa.exp_sig = '0; ifb.exp_sig = '0; ifc.exp_sig = '0;
`endif

    // 1. reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_sig_a",  ifa.signature, 8'h00);
    chk("rst_sig_b",  ifb.signature, 8'hFF);
    chk("rst_sig_c",  ifc.signature, 32'hFFFF_FFFF);
    chk("rst_busy_a", ifa.busy, 1'b0);
    chk("rst_done_a", ifa.done, 1'b0);
    chk("rst_cnt_a",  ifa.sample_cnt, 0);
    chk("rst_state_c", ifc.state, IDLE);

    // din_valid outside RUN is ignored
    ifb.din_valid = 1'b1;
    ifb.din       = 16'h5A5A;
    tick();
    chk("idle_valid_sig_b", ifb.signature, 8'hFF);
    chk("idle_valid_cnt_b", ifb.sample_cnt, 0);

    // 2/3. start with din_valid in the start cycle (ignored)
    ifa.start = 1'b1; ifa.din_valid = 1'b1; ifa.din = 16'hFFFF;
    ifb.start = 1'b1; ifb.din_valid = 1'b1; ifb.din = 16'hFFFF;
    tick();
    ifa.start = 1'b0; ifb.start = 1'b0;
    chk("start_sig_a",  ifa.signature, 8'h00);
    chk("start_cnt_a",  ifa.sample_cnt, 0);
    chk("start_busy_a", ifa.busy, 1'b1);
    chk("start_sig_b",  ifb.signature, 8'hFF);
    ifa.din = 16'h1234;
    ifb.din = 16'h0000;
    tick();
    ifb.din_valid = 1'b0;
    chk("one_sample_a", ifa.signature, 8'h26);
    chk("one_cnt_a",    ifa.sample_cnt, 1);
    chk("one_sample_b", ifb.signature, 8'hE3);
    chk("one_cnt_b",    ifb.sample_cnt, 1);

    // 4. remaining valid pattern 0,1,0,1,1 with a start attempt mid-run
    m_a   = 64'h26;
    cnt_a = 1;
    pat   = '{0, 1, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      ifa.din_valid = pat[i][0];
      ifa.din       = 16'($urandom);
      ifa.start     = (i == 0);
      tick();
      if (pat[i] == 1 && cnt_a < 4) begin
        m_a = model_step(m_a, {272'b0, ifa.din}, 16, 8, 64'h1D);
        cnt_a++;
      end
      chk("pat_sig_a",  ifa.signature, m_a);
      chk("pat_cnt_a",  ifa.sample_cnt, cnt_a);
      chk("pat_done_a", ifa.done, (cnt_a == 4));
      chk("pat_busy_a", ifa.busy, (cnt_a != 4));
    end
    ifa.start = 1'b0; ifa.din_valid = 1'b0;
    chk("stall_hold_b", ifb.signature, 8'hE3);

    // 5. reset after 2 of 4 samples, then a clean rerun with the same data
    for (int i = 0; i < 4; i++) d4[i] = 16'($urandom);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ifa.din_valid = 1'b1; ifa.din = d4[i];
      tick();
    end
    chk("part_cnt_a", ifa.sample_cnt, 2);
    rst = 1'b1; ifa.din = d4[2];
    tick();
    rst = 1'b0; ifa.din_valid = 1'b0;
    chk("midrst_sig_a",   ifa.signature, 8'h00);
    chk("midrst_cnt_a",   ifa.sample_cnt, 0);
    chk("midrst_state_a", ifa.state, IDLE);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    m_a = 64'h00;
    for (int i = 0; i < 4; i++) begin
      ifa.din_valid = 1'b1; ifa.din = d4[i];
      m_a = model_step(m_a, {272'b0, d4[i]}, 16, 8, 64'h1D);
      tick();
    end
    ifa.din_valid = 1'b0;
    chk("rerun_sig_a",  ifa.signature, m_a);
    chk("rerun_done_a", ifa.done, 1'b1);
    tick();
    chk("done_hold_a", ifa.done, 1'b1);
    chk("done_sig_hold_a", ifa.signature, m_a);
    // DONE -> RUN on start
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("restart_sig_a",  ifa.signature, 8'h00);
    chk("restart_cnt_a",  ifa.sample_cnt, 0);
    chk("restart_busy_a", ifa.busy, 1'b1);
    chk("restart_done_a", ifa.done, 1'b0);

    // 6. wide configuration, random data with random stalls
    for (int i = 0; i < CN; i++) din_c[i] = rand_wide();
    clean_c = 64'hFFFF_FFFF;
    for (int i = 0; i < CN; i++) clean_c = model_step(clean_c, {4'b0, din_c[i]}, CW, 32, 64'h04C1_1DB7);
`ifdef FUZZ_SIG_CMP_EN
    ifc.exp_sig = clean_c[31:0];
`endif
    run_c(-1, 0);
    chk("c_clean_final", ifc.signature, clean_c);
    run_c($urandom_range(0, CN - 1), $urandom_range(0, CW - 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
